// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the 7-segment scan driver.
//   SEG_BLANK     : segment pattern with every (active-low) segment off
//   scan_state_t  : scan FSM state encoding
//   clog2         : ceiling log2 with a minimum result of 1 (sizes counters/indices)
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Width needed to hold values 0..n-1; never returns 0 so a 1-entry range
  // still gets a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// slot_timer: per-digit slot counter for the scan driver.
//   clk, reset  : clock / synchronous active-high reset
//   run         : advance the counter this cycle
//   clr         : force the counter back to 0 (takes priority over run)
//   count       : current position inside the slot, 0..SLOT_CYCLES-1
//   blank_done  : high while running on the last blanking cycle
//   slot_done   : high while running on the last cycle of the slot; the
//                 counter wraps to 0 on the following edge
module slot_timer
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int CW = clog2(SLOT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          blank_done,
  output logic          slot_done
);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign count      = count_reg;
  assign blank_done = run && (count_reg == BLANK_LAST);
  assign slot_done  = run && (count_reg == SLOT_LAST);

  // Explicit wrap at the end of the slot, so the counter never relies on
  // binary overflow (SLOT_CYCLES need not be a power of two).
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (run) begin
      count_next = slot_done ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scan controller.
//   clk, reset  : clock / synchronous active-high reset
//   enable      : 1 = scanning, 0 = display dark with scan position held
//   seg_in      : packed active-low patterns, digit i at [7*i+6:7*i]
//   digit_mask  : 1 = digit skipped (stays dark for its slot)
//   seg_out     : registered active-low segment pattern
//   an          : registered active-low anodes, at most one bit low
//   digit_idx   : index of the current slot
//   frame_tick  : one-cycle pulse as the last digit's slot wraps to digit 0
// Each slot is SLOT_CYCLES long and begins with BLANK_CYCLES of all-dark
// output, so consecutive drives are always separated by a dark gap.
module seg_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int IW = clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_tick
);

  localparam int CW = clog2(SLOT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [6:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  tick_reg, tick_next;

  logic [CW-1:0] slot_count;
  logic          blank_done;
  logic          slot_done;
  logic          timer_run;
  logic          timer_clr;

  // Unpack the per-digit patterns so the mux below indexes whole digits.
  logic [6:0] seg_arr [NUM_DIGITS];
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
      assign seg_arr[gi] = seg_in[7*gi +: 7];
    end
  endgenerate

  // The counter only runs inside a slot; IDLE (or a dropped enable) parks it
  // at 0 so re-entry always begins with a full blanking interval.
  assign timer_run = enable && (state_reg != IDLE);
  assign timer_clr = !enable || (state_reg == IDLE);

  slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (timer_run),
    .clr       (timer_clr),
    .count     (slot_count),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  // Next-state, next-index and next-output logic. The output registers are
  // loaded from the *next* state so seg_out/an line up with the FSM state
  // in the same cycle, and seg_in reaches seg_out one edge after it changes.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tick_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (enable) state_next = BLANK;
      end
      BLANK: begin
        if (blank_done) state_next = DRIVE;
      end
      DRIVE: begin
        if (slot_done) begin
          state_next = BLANK;
          idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
          tick_next  = (idx_reg == LAST_IDX);
        end
      end
      default: state_next = IDLE;
    endcase

    // Dropping enable overrides everything: go dark, keep the position.
    if (!enable) begin
      state_next = IDLE;
      idx_next   = idx_reg;
      tick_next  = 1'b0;
    end

    an_next  = '1;
    seg_next = SEG_BLANK;
    if ((state_next == DRIVE) && !digit_mask[idx_next]) begin
      an_next[idx_next] = 1'b0;
      seg_next          = seg_arr[idx_next];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      seg_reg   <= SEG_BLANK;
      an_reg    <= '1;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
      tick_reg  <= tick_next;
    end
  end

  assign seg_out    = seg_reg;
  assign an         = an_reg;
  assign digit_idx  = idx_reg;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed test of seg_scan_driver (4 digits, 8-cycle
// slots, 2 blank cycles) with a cycle-level reference model and literal
// spot checks at hand-computed points of the timeline.
module tb_seg_scan_driver;
  import display_pkg::*;

  localparam int N     = 4;
  localparam int SLOT  = 8;
  localparam int BLNK  = 2;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [7*N-1:0]   seg_in;
  logic [N-1:0]     digit_mask;
  logic [6:0]       seg_out;
  logic [N-1:0]     an;
  logic [1:0]       digit_idx;
  logic             frame_tick;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  seg_scan_driver #(
    .NUM_DIGITS  (N),
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLNK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .seg_in    (seg_in),
    .digit_mask(digit_mask),
    .seg_out   (seg_out),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: scanning flag, position inside the current slot and the
  // current digit, advanced once per clock from the inputs seen at that edge.
  bit         m_on  = 0;
  int         m_pos = 0;
  int         m_idx = 0;
  logic [3:0] e_an  = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic [1:0] e_idx = 2'd0;
  logic       e_tick = 1'b0;

  // Inputs change only at posedge+1, so at the negedge the inputs on the
  // bus are exactly those the next rising edge will capture.
  always @(negedge clk) begin
    if (check_en) begin
      chk("seg_out", 32'(seg_out), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("digit_idx", 32'(digit_idx), 32'(e_idx));
      chk("frame_tick", 32'(frame_tick), 32'(e_tick));
      chk("an_onehot_low", 32'($countones(~an) <= 1), 32'd1);
      if (dut.state_reg == BLANK) chk("an_dark_in_blank", 32'(an), 32'hF);
    end
    e_tick = 1'b0;
    if (reset) begin
      m_on = 0; m_pos = 0; m_idx = 0;
    end else if (!enable) begin
      m_on = 0; m_pos = 0;
    end else if (!m_on) begin
      m_on = 1; m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos == SLOT) begin
        m_pos  = 0;
        e_tick = (m_idx == N - 1);
        m_idx  = (m_idx + 1) % N;
      end
    end
    e_idx = 2'(m_idx);
    if (m_on && m_pos >= BLNK && !digit_mask[m_idx]) begin
      e_an  = ~(4'b0001 << m_idx);
      e_seg = seg_in[7*m_idx +: 7];
    end else begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    seg_in     = {7'h79, 7'h24, 7'h30, 7'h40};
    digit_mask = '0;

    // 1: reset held three edges with enable high
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_en = 1;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg_out), 32'h7F);
      chk("rst_idx", 32'(digit_idx), 32'd0);
      chk("rst_tick", 32'(frame_tick), 32'd0);
    end
    reset = 1'b0;

    // 2: normal scan
    step(1);                                  // first BLANK cycle of digit 0
    chk("blank0_an", 32'(an), 32'hF);
    step(2);                                  // first DRIVE cycle of digit 0
    chk("drive0_an", 32'(an), 32'b1110);
    chk("drive0_seg", 32'(seg_out), 32'h40);
    step(29);                                 // last DRIVE cycle of digit 3
    chk("drive3_an", 32'(an), 32'b0111);
    chk("drive3_seg", 32'(seg_out), 32'h79);
    chk("drive3_tick", 32'(frame_tick), 32'd0);
    step(1);                                  // wrap to digit 0
    chk("wrap_tick", 32'(frame_tick), 32'd1);
    chk("wrap_idx", 32'(digit_idx), 32'd0);

    // 3: digit 2 masked
    digit_mask = 4'b0100;
    step(19);                                 // DRIVE phase of digit 2
    chk("mask_idx", 32'(digit_idx), 32'd2);
    chk("mask_an", 32'(an), 32'hF);
    chk("mask_seg", 32'(seg_out), 32'h7F);
    step(13);
    chk("mask_period_tick", 32'(frame_tick), 32'd1);
    digit_mask = '0;

    // 4: change digit 1 mid-DRIVE
    step(11);
    chk("d1_before_seg", 32'(seg_out), 32'h30);
    chk("d1_before_an", 32'(an), 32'b1101);
    seg_in[13:7] = 7'h12;
    step(1);
    chk("d1_after_seg", 32'(seg_out), 32'h12);
    chk("d1_after_an", 32'(an), 32'b1101);

    // 5: enable dropped for 5 cycles during digit 2's DRIVE
    step(8);
    chk("d2_pre_an", 32'(an), 32'b1011);
    enable = 1'b0;
    step(1);
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_seg", 32'(seg_out), 32'h7F);
    chk("dis_idx", 32'(digit_idx), 32'd2);
    step(4);
    enable = 1'b1;
    step(1);
    chk("reen_blank_an", 32'(an), 32'hF);
    chk("reen_idx", 32'(digit_idx), 32'd2);
    step(2);
    chk("reen_drive_an", 32'(an), 32'b1011);
    chk("reen_drive_seg", 32'(seg_out), 32'h24);
    step(5);
    chk("reen_last_an", 32'(an), 32'b1011);
    step(1);
    chk("reen_next_an", 32'(an), 32'hF);
    chk("reen_next_idx", 32'(digit_idx), 32'd3);

    // 6: reset pulse during digit 3's DRIVE
    step(3);
    chk("d3_an", 32'(an), 32'b0111);
    reset = 1'b1;
    step(1);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_idx", 32'(digit_idx), 32'd0);
    reset = 1'b0;
    step(1);
    chk("restart_idx", 32'(digit_idx), 32'd0);
    chk("restart_tick", 32'(frame_tick), 32'd0);
    step(2);
    chk("restart_an", 32'(an), 32'b1110);
    chk("restart_seg", 32'(seg_out), 32'h40);
    step(1);
    chk("aborted_tick", 32'(frame_tick), 32'd0);
    step(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
